// File: rtl/block_serializer.sv
// Ping-pong block buffer draining wide sorted blocks as single records; `SORTCHK_EN adds an ascending-key check on ERR.
// Record 0 valid one edge after a block is accepted; DOT/DOTEN/DOTLAST hold while DOTRDY=0, DINRDY drops when both slots are full.
module block_serializer #(
    parameter int P_LOG = 3,
    parameter int DATW  = 64,
    parameter int KEYW  = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [(DATW<<P_LOG)-1:0] DIN,
    input  logic                     DINEN,
    output logic                     DINRDY,
    output logic [DATW-1:0]          DOT,
    output logic                     DOTEN,
    input  logic                     DOTRDY,
    output logic                     DOTLAST,
    output logic                     OVF,
    output logic                     ERR
);
    localparam int BLKW = DATW << P_LOG;

    logic [BLKW-1:0]  slot_q [2];
    logic [1:0]       valid_q, valid_d;
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [P_LOG-1:0] idx_q, idx_d;
    logic [DATW-1:0]  dot_q, dot_d;
    logic             doten_q, doten_d;
    logic             dotlast_q, dotlast_d;
    logic             ovf_q, ovf_d;
    logic             wr_en;
    logic             out_free;
    logic             load;

    assign DINRDY   = !(valid_q[0] && valid_q[1]);
    assign wr_en    = DINEN && DINRDY;
    assign out_free = !doten_q || DOTRDY;
    assign load     = out_free && valid_q[rp_q];

    always_comb begin
        valid_d   = valid_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        idx_d     = idx_q;
        dot_d     = dot_q;
        doten_d   = doten_q;
        dotlast_d = dotlast_q;
        ovf_d     = ovf_q;

        if (load) begin
            dot_d     = slot_q[rp_q][int'(idx_q)*DATW +: DATW];
            doten_d   = 1'b1;
            dotlast_d = &idx_q;
            idx_d     = idx_q + 1'b1;
            if (&idx_q) begin
                valid_d[rp_q] = 1'b0;
                rp_d          = !rp_q;
            end
        end else if (out_free) begin
            // Only drop DOTEN once the held record has been taken.
            doten_d   = 1'b0;
            dotlast_d = 1'b0;
        end

        // The write slot is always the free one, so it never collides with the read-side clear.
        if (wr_en) begin
            valid_d[wp_q] = 1'b1;
            wp_d          = !wp_q;
        end

        if (DINEN && !DINRDY) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q   <= 2'b00;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            idx_q     <= '0;
            dot_q     <= '0;
            doten_q   <= 1'b0;
            dotlast_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            idx_q     <= idx_d;
            dot_q     <= dot_d;
            doten_q   <= doten_d;
            dotlast_q <= dotlast_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            slot_q[wp_q] <= DIN;
        end
    end

    assign DOT     = dot_q;
    assign DOTEN   = doten_q;
    assign DOTLAST = dotlast_q;
    assign OVF     = ovf_q;

`ifdef SORTCHK_EN
    logic [KEYW-1:0] prev_q, prev_d;
    logic            first_q, first_d;
    logic            err_q, err_d;

    always_comb begin
        prev_d  = prev_q;
        first_d = first_q;
        err_d   = err_q;
        if (doten_q && DOTRDY) begin
            if (!first_q && (dot_q[KEYW-1:0] < prev_q)) begin
                err_d = 1'b1;
            end
            prev_d  = dot_q[KEYW-1:0];
            first_d = dotlast_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q  <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign ERR = err_q;
`else
    // Without the checker ERR only reflects an impossible key width; 0 for any legal configuration.
    assign ERR = (KEYW > DATW);
`endif

endmodule

// File: tb/tb_block_serializer.sv
// Scoreboard bench for block_serializer: records pushed when a block is driven, popped on each accepted output beat.
module tb_block_serializer;
    localparam int P_LOG = 3;
    localparam int DATW  = 64;
    localparam int KEYW  = 32;
    localparam int N     = 1 << P_LOG;

    typedef logic [31:0] keys_t [N];
    typedef struct {
        logic [DATW-1:0] dat;
        logic            last;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [DATW*N-1:0]   DIN = '0;
    logic                DINEN = 1'b0;
    logic                DINRDY;
    logic [DATW-1:0]     DOT;
    logic                DOTEN;
    logic                DOTRDY = 1'b0;
    logic                DOTLAST;
    logic                OVF;
    logic                ERR;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb [$];
    exp_t mon_e;

    block_serializer #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(KEYW)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DINEN(DINEN), .DINRDY(DINRDY),
        .DOT(DOT), .DOTEN(DOTEN), .DOTRDY(DOTRDY), .DOTLAST(DOTLAST),
        .OVF(OVF), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DATW-1:0] mkrec(input logic [31:0] key);
        return {key ^ 32'hDEAD_BEEF, key};
    endfunction

    function automatic keys_t seq(input int base);
        keys_t s;
        for (int i = 0; i < N; i++) s[i] = 32'(base + i);
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one block strobe for the next edge; records are expected only if the bench predicts acceptance.
    task automatic present(input keys_t k, input bit acc);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            DIN[i*DATW +: DATW] = mkrec(k[i]);
            if (acc) begin
                e.dat  = mkrec(k[i]);
                e.last = (i == N-1);
                sb.push_back(e);
            end
        end
        DINEN = 1'b1;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        DINEN  = 1'b0;
        DOTRDY = 1'b0;
        tick();
        tick();
        sb.delete();
        RST = 1'b0;
        tick();
    endtask

    always @(negedge CLK) begin
        if (!RST && DOTEN === 1'b1 && DOTRDY === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_beat dot=%h last=%b expected=none", DOT, DOTLAST);
            end else begin
                mon_e = sb.pop_front();
                if (DOT !== mon_e.dat || DOTLAST !== mon_e.last) begin
                    failures++;
                    $display("FAIL sb_record dot=%h last=%b expected dot=%h last=%b",
                             DOT, DOTLAST, mon_e.dat, mon_e.last);
                end
            end
        end
    end

    task automatic drain(input string name);
        DOTRDY = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || DOTEN !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain left=%0d doten=%b expected left=0 doten=0", name, sb.size(), DOTEN);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (DOTEN !== 1'b0 || DOTLAST !== 1'b0 || DOT !== '0 || OVF !== 1'b0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs doten=%b last=%b dot=%h ovf=%b err=%b expected all 0",
                     DOTEN, DOTLAST, DOT, OVF, ERR);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (DINRDY !== 1'b1) begin
            failures++;
            $display("FAIL reset_dinrdy got=%b expected=1", DINRDY);
        end
    endtask

    task automatic test_single();
        DOTRDY = 1'b1;
        present(seq(1), 1'b1);
        tick();
        DINEN = 1'b0;
        checks++;
        if (DOTEN !== 1'b0) begin
            failures++;
            $display("FAIL single_early doten=%b expected=0", DOTEN);
        end
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (DOTEN !== 1'b1 || DOT[31:0] !== 32'(i + 1) || DOTLAST !== (i == N-1)) begin
                failures++;
                $display("FAIL single_beat%0d doten=%b key=%0d last=%b expected doten=1 key=%0d last=%b",
                         i, DOTEN, DOT[31:0], DOTLAST, i + 1, (i == N-1));
            end
            tick();
        end
        checks++;
        if (DOTEN !== 1'b0 || OVF !== 1'b0 || ERR !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL single_end doten=%b ovf=%b err=%b left=%0d expected 0 0 0 0",
                     DOTEN, OVF, ERR, sb.size());
        end
    endtask

    task automatic test_stall();
        logic [DATW-1:0] hold_dat;
        logic            hold_en;
        logic            stalled;
        DOTRDY = 1'b0;
        present(seq(1), 1'b1);
        tick();
        DINEN = 1'b0;
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            DOTRDY   = (c % 2 == 1);
            hold_en  = DOTEN;
            hold_dat = DOT;
            stalled  = !DOTRDY;
            tick();
            if (stalled && hold_en) begin
                checks++;
                if (DOTEN !== 1'b1 || DOT !== hold_dat) begin
                    failures++;
                    $display("FAIL stall_hold doten=%b dot=%h expected doten=1 dot=%h", DOTEN, DOT, hold_dat);
                end
            end
        end
        drain("stall");
    endtask

    task automatic test_overflow();
        DOTRDY = 1'b0;
        present(seq(1), 1'b1);
        tick();
        present(seq(9), 1'b1);
        tick();
        checks++;
        if (DINRDY !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full_dinrdy got=%b expected=0", DINRDY);
        end
        present(seq(100), 1'b0);
        tick();
        DINEN = 1'b0;
        checks++;
        if (OVF !== 1'b1 || DOT[31:0] !== 32'd1) begin
            failures++;
            $display("FAIL ovf_flag ovf=%b key=%0d expected ovf=1 key=1", OVF, DOT[31:0]);
        end
        DOTRDY = 1'b1;
        for (int i = 0; i < N-1; i++) begin
            tick();
            checks++;
            if (DOT[31:0] !== 32'(i + 2) || DINRDY !== (i + 2 == N)) begin
                failures++;
                $display("FAIL ovf_dinrdy key=%0d dinrdy=%b expected key=%0d dinrdy=%b",
                         DOT[31:0], DINRDY, i + 2, (i + 2 == N));
            end
        end
        drain("ovf");
        checks++;
        if (OVF !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b expected=1", OVF);
        end
    endtask

    task automatic test_back_to_back();
        DOTRDY = 1'b1;
        present(seq(1), 1'b1);
        tick();
        present(seq(9), 1'b1);
        tick();
        DINEN = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            checks++;
            if (DOTEN !== 1'b1 || DOT[31:0] !== 32'(i + 1) || DOTLAST !== (i == N-1 || i == 2*N-1)) begin
                failures++;
                $display("FAIL b2b_beat%0d doten=%b key=%0d last=%b expected doten=1 key=%0d last=%b",
                         i, DOTEN, DOT[31:0], DOTLAST, i + 1, (i == N-1 || i == 2*N-1));
            end
            tick();
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        DOTRDY = 1'b1;
        present(seq(1), 1'b1);
        tick();
        DINEN = 1'b0;
        tick();
        tick();
        tick();
        RST = 1'b1;
        sb.delete();
        tick();
        checks++;
        if (DOTEN !== 1'b0 || DOTLAST !== 1'b0 || DOT !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs doten=%b last=%b dot=%h expected 0 0 0", DOTEN, DOTLAST, DOT);
        end
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (DOTEN !== 1'b0 || DINRDY !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_stale cyc=%0d doten=%b dinrdy=%b expected doten=0 dinrdy=1", i, DOTEN, DINRDY);
            end
        end
        present(seq(21), 1'b1);
        tick();
        DINEN = 1'b0;
        tick();
        checks++;
        if (DOTEN !== 1'b1 || DOT[31:0] !== 32'd21) begin
            failures++;
            $display("FAIL rstmid_restart doten=%b key=%0d expected doten=1 key=21", DOTEN, DOT[31:0]);
        end
        drain("rstmid");
    endtask

`ifdef SORTCHK_EN
    task automatic test_sortchk();
        keys_t k;
        bit    seen4;
        do_reset();
        DOTRDY = 1'b1;
        present(seq(1), 1'b1);
        tick();
        present(seq(1), 1'b1);
        tick();
        DINEN = 1'b0;
        drain("chk_first");
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL chk_first_record err=%b expected=0", ERR);
        end
        k = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd4, 32'd6, 32'd7, 32'd8};
        present(k, 1'b1);
        tick();
        DINEN = 1'b0;
        seen4 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (DOTEN && DOTRDY && DOT[31:0] == 32'd4) seen4 = 1'b1;
            tick();
            checks++;
            if (ERR !== seen4) begin
                failures++;
                $display("FAIL chk_rise cyc=%0d err=%b expected=%b", c, ERR, seen4);
            end
        end
        present(seq(1), 1'b1);
        tick();
        DINEN = 1'b0;
        drain("chk_sticky");
        checks++;
        if (ERR !== 1'b1) begin
            failures++;
            $display("FAIL chk_sticky err=%b expected=1", ERR);
        end
        do_reset();
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL chk_reset err=%b expected=0", ERR);
        end
    endtask
`else
    task automatic test_err_tied();
        keys_t k;
        for (int i = 0; i < N; i++) k[i] = 32'(N - i);
        DOTRDY = 1'b1;
        present(k, 1'b1);
        tick();
        DINEN = 1'b0;
        drain("err_tied");
        checks++;
        if (ERR !== 1'b0) begin
            failures++;
            $display("FAIL err_tied err=%b expected=0", ERR);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        do_reset();
        test_back_to_back();
        test_reset_mid();
`ifdef SORTCHK_EN
        test_sortchk();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_serializer.md
Name: block_serializer

Overview:
- Drains wide sorted blocks from EVEN_ODD (DOT/DOTEN) and emits them as a stream of single records with a valid/ready handshake.
- Sits downstream of the sorting network: its DIN/DINEN connect directly to the network's DOT/DOTEN.
- Two-block ping-pong buffer absorbs back-to-back network outputs while the stream consumer applies backpressure.

Parameters:
- P_LOG, 3, log2 of records per block (2^P_LOG records).
- DATW, 64, record width in bits.
- KEYW, 32, key width in bits; the key is bits [KEYW-1:0] of each record.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- DIN  in  DATW<<P_LOG  block; record i at [DATW*(i+1)-1:DATW*i].
- DINEN  in  1  one-cycle block-valid strobe.
- DINRDY  out  1  at least one buffer slot free.
- DOT  out  DATW  current output record.
- DOTEN  out  1  DOT valid.
- DOTRDY  in  1  consumer accepts DOT.
- DOTLAST  out  1  DOT is record 2^P_LOG-1 of its block.
- OVF  out  1  sticky: DINEN arrived while DINRDY=0.
- ERR  out  1  sticky order-check error (see Optional Feature).

Behaviour:
- Reset (sync, RST=1 at edge): both slots empty, slot pointers=0, record index=0, DOTEN=0, DOTLAST=0, DOT=0, OVF=0, ERR=0, DINRDY=1 from the next cycle.
- Storage: slots 0/1, each with a valid bit. Write pointer wp and read pointer rp are 1-bit and toggle (wrap 1->0).
- DINRDY = !(valid[0] & valid[1]), computed from register state only.
- DINEN with DINRDY=1: DIN captured into slot wp, valid[wp] set, wp toggles.
- DINEN with DINRDY=0: block dropped, OVF set and held until reset; buffer state unchanged.
- Output register: loads when (!DOTEN || DOTRDY) and valid[rp]. Loads record idx of slot rp; DOTEN=1; DOTLAST=(idx==2^P_LOG-1); idx increments.
  - On the last record: idx wraps to 0, valid[rp] cleared, rp toggles.
- If the load condition holds but no slot is valid: DOTEN becomes 0 only when DOTRDY=1, so DOT is never lost.
- DOTEN=1 and DOTRDY=0: DOT, DOTEN and DOTLAST hold stable.
- Latency: a block accepted at edge t into an empty buffer with an idle output has record 0 valid after edge t+1.
- Records are emitted in index order 0..2^P_LOG-1, i.e. ascending key for network output.
- Throughput: DOTRDY held 1 gives one record per cycle, and consecutive blocks stream with no bubble.
- Slot freed and DINEN in the same cycle: a slot freed at edge t is not visible in DINRDY until after edge t.
  - If the other slot is free, DINEN is accepted normally.
  - If the other slot is busy, DINRDY was 0, so OVF is set.
- Reset mid-block: all buffered and in-flight records are discarded with no partial output after reset.

Optional Feature:
- Macro SORTCHK_EN.
- Defined:
  - Each accepted output beat (DOTEN & DOTRDY) compares its key with the previous accepted key of the same block.
  - key < previous sets ERR (sticky until reset). The first record of a block is not compared.
  - Keys compare unsigned.
  - Adds one KEYW-bit register and a first-of-block flag.
- Undefined: ERR tied to 0 and no compare logic is present.

Test Plan:
- P_LOG=3, block keys 1..8, DOTRDY=1, one DINEN: DOT keys 1,2,...,8 on 8 consecutive cycles starting 2 edges after DINEN; DOTLAST only with key 8; OVF=0, ERR=0.
- DOTRDY toggling 1,0,1,0...: each record held while DOTRDY=0; sequence 1..8 emitted exactly once with no duplicates.
- Three DINEN on consecutive cycles, DOTRDY=0: blocks 1 and 2 accepted; DINRDY=0 at the third strobe; OVF=1.
  - Then DOTRDY=1: 16 records from blocks 1 and 2 in order, and DINRDY returns to 1 after the 8th record is loaded.
- Two blocks (keys 1..8 then 9..16) back to back, DOTRDY=1: 16 records on 16 consecutive cycles with no bubble; DOTLAST at keys 8 and 16.
- RST asserted after the 3rd record of a block: DOTEN=0 after the reset edge and no stale record appears; a new block after reset starts at record 0.
- SORTCHK_EN defined, block keys 1,2,3,5,4,6,7,8: ERR rises after the beat with key 4 and stays 1. A following block 1..8 does not clear ERR, and the first-record comparison of 8 vs 1 does not fire.
